inst_fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipeline. Owns the PC and drives the instruction-ROM address.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/inst_fetch_stage_if.sv | 46 ++++
 rtl/pc_reg.sv | 36 +++
 rtl/inst_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding and default widths.
// Used by the instruction ROM and the fetch stage.
package pipe_pkg;

  localparam int unsigned DEFAULT_N     = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  // True when a word-index PC addresses a real ROM location.
  function automatic logic pc_in_range(logic [31:0] pc, int unsigned depth);
    return pc < depth;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect inputs, ROM address/data and the IF/ID register.
// master = the fetch stage, slave = its surroundings (ROM, hazard unit, decode).
interface inst_fetch_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) ();

  logic         stall;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] rom_address;
  logic [N-1:0] rom_instruction;
  logic [N-1:0] if_id_instruction;
  logic [N-1:0] if_id_pc;
  logic [N-1:0] if_id_pc_plus1;
  logic         if_id_valid;
  logic         halted;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  rom_instruction,
    output rom_address,
    output if_id_instruction,
    output if_id_pc,
    output if_id_pc_plus1,
    output if_id_valid,
    output halted
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    output rom_instruction,
    input  rom_address,
    input  if_id_instruction,
    input  if_id_pc,
    input  if_id_pc_plus1,
    input  if_id_valid,
    input  halted
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with next-PC mux: load (redirect) > increment > hold.
// PC is a word index; increment wraps mod 2^N.
module pc_reg #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [N-1:0] target,
  output logic [N-1:0] pc
);

  logic [N-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned  N        = DEFAULT_N,
  parameter int unsigned  DEPTH    = DEFAULT_DEPTH,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_stage_if.master  fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         cnt_fetched,
  output logic [31:0]         cnt_stall,
  output logic [31:0]         cnt_flush
`endif
);

  localparam logic [N-1:0] DepthW = N'(DEPTH);
  localparam logic [N-1:0] LastPc = N'(DEPTH - 1);
  localparam logic [N-1:0] Nop    = N'(NOP_WORD);

  fetch_state_t state_q, state_d;

  logic [N-1:0] pc;
  logic         pc_load, pc_inc;
  logic         pc_ok, redir_ok;
  logic         advance, run_stall, run_redirect;

  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] ifpc_q, ifpc_d;
  logic [N-1:0] ifp1_q, ifp1_d;
  logic         valid_q, valid_d;

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (fif.redirect_pc),
    .pc     (pc)
  );

  assign pc_ok    = pc < DepthW;
  assign redir_ok = fif.redirect_pc < DepthW;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    ifp1_d       = ifp1_q;
    valid_d      = valid_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    advance      = 1'b0;
    run_stall    = 1'b0;
    run_redirect = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (fif.redirect_valid) begin
          run_redirect = 1'b1;
          pc_load      = 1'b1;
          valid_d      = 1'b0;
          instr_d      = Nop;
          if (!redir_ok) state_d = HALT;
        end else if (fif.stall) begin
          run_stall = 1'b1;
        end else if (pc_ok) begin
          advance = 1'b1;
          pc_inc  = 1'b1;
          instr_d = fif.rom_instruction;
          ifpc_d  = pc;
          ifp1_d  = pc + N'(1);
          valid_d = 1'b1;
          if (pc == LastPc) state_d = HALT;
        end else begin
          // Only reachable with an out-of-range RESET_PC: never capture it.
          valid_d = 1'b0;
          state_d = HALT;
        end
      end
      HALT: begin
        if (fif.redirect_valid && redir_ok) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!fif.stall) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      instr_q <= '0;
      ifpc_q  <= '0;
      ifp1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifp1_q  <= ifp1_d;
      valid_q <= valid_d;
    end
  end

  assign fif.rom_address       = pc;
  assign fif.if_id_instruction = instr_q;
  assign fif.if_id_pc          = ifpc_q;
  assign fif.if_id_pc_plus1    = ifp1_q;
  assign fif.if_id_valid       = valid_q;
  assign fif.halted            = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (advance)      fetched_q <= fetched_q + 32'd1;
      if (run_stall)    stall_q   <= stall_q + 32'd1;
      if (run_redirect) flush_q   <= flush_q + 32'd1;
    end
  end

  assign cnt_fetched = fetched_q;
  assign cnt_stall   = stall_q;
  assign cnt_flush   = flush_q;
`else
  logic unused_cnt;
  assign unused_cnt = advance ^ run_stall ^ run_redirect;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: the driver queues expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_inst_fetch_stage;

  localparam int unsigned M_ADDR  = 1;
  localparam int unsigned M_VALID = 2;
  localparam int unsigned M_PC    = 4;
  localparam int unsigned M_P1    = 8;
  localparam int unsigned M_INS   = 16;
  localparam int unsigned M_HALT  = 32;
  localparam int unsigned M_CNT   = 64;
  localparam int unsigned M_ALL   = 63;

  typedef struct {
    string       name;
    int unsigned m;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] p1;
    logic [31:0] ins;
    logic        halted;
    logic [31:0] cf;
    logic [31:0] cs;
    logic [31:0] cl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rom [32];

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  inst_fetch_stage_if #(.N(32)) fif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetched, cnt_stall, cnt_flush;
`endif

  inst_fetch_stage #(
    .N        (32),
    .DEPTH    (32),
    .RESET_PC (32'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_fetched (cnt_fetched),
    .cnt_stall   (cnt_stall),
    .cnt_flush   (cnt_flush)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (fif.rom_address < 32'd32) fif.rom_instruction = rom[fif.rom_address[4:0]];
    else                          fif.rom_instruction = 32'hDEAD_BEEF;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(string nm, int unsigned m, logic [31:0] addr, logic valid,
                              logic [31:0] pc, logic [31:0] p1, logic [31:0] ins,
                              logic halted);
    exp_t e;
    e.name = nm; e.m = m; e.addr = addr; e.valid = valid; e.pc = pc; e.p1 = p1;
    e.ins = ins; e.halted = halted; e.cf = '0; e.cs = '0; e.cl = '0;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the state expected after the
  // following rising edge.
  task automatic cyc(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                     input exp_t e);
    @(negedge clk);
    rst = r;
    fif.stall = st;
    fif.redirect_valid = rv;
    fif.redirect_pc = rpc;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if ((e.m & M_ADDR) != 0)  chk({e.name, " rom_address"}, fif.rom_address, e.addr);
        if ((e.m & M_VALID) != 0) chk({e.name, " if_id_valid"}, {31'b0, fif.if_id_valid},
                                      {31'b0, e.valid});
        if ((e.m & M_PC) != 0)    chk({e.name, " if_id_pc"}, fif.if_id_pc, e.pc);
        if ((e.m & M_P1) != 0)    chk({e.name, " if_id_pc_plus1"}, fif.if_id_pc_plus1, e.p1);
        if ((e.m & M_INS) != 0)   chk({e.name, " if_id_instruction"}, fif.if_id_instruction,
                                      e.ins);
        if ((e.m & M_HALT) != 0)  chk({e.name, " halted"}, {31'b0, fif.halted},
                                      {31'b0, e.halted});
`ifdef FETCH_PERF_CNT_EN
        if ((e.m & M_CNT) != 0) begin
          chk({e.name, " cnt_fetched"}, cnt_fetched, e.cf);
          chk({e.name, " cnt_stall"}, cnt_stall, e.cs);
          chk({e.name, " cnt_flush"}, cnt_flush, e.cl);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    exp_t e;
    for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 + i * 32'h0000_0111;
    fif.stall = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc = '0;

    // Reset held 3 cycles.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, mk("reset", M_ALL, 0, 0, 0, 0, 0, 0));
    // BOOT: no capture, PC holds.
    cyc(0, 0, 0, 0, mk("boot", M_ADDR | M_VALID | M_HALT, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, mk("fetch", M_ALL, i + 1, 1, i, i + 1, rom[i], 0));

    // Stall holds PC and IF/ID.
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, mk("stall", M_ALL, 3, 1, 2, 3, rom[2], 0));
    cyc(0, 0, 0, 0, mk("unstall", M_ALL, 4, 1, 3, 4, rom[3], 0));

    // Redirect beats stall and flushes.
    cyc(0, 1, 1, 9, mk("redir9", M_ADDR | M_VALID | M_INS | M_HALT | M_PC, 9, 0, 3, 0, 0, 0));
    cyc(0, 0, 0, 0, mk("after9", M_ALL, 10, 1, 9, 10, rom[9], 0));

    // Free-run to the last ROM word.
    for (int i = 10; i < 32; i++)
      cyc(0, 0, 0, 0, mk("run", M_ALL, i + 1, 1, i, i + 1, rom[i], (i == 31)));
    cyc(0, 1, 0, 0, mk("halt_stall", M_ALL, 32, 1, 31, 32, rom[31], 1));
    cyc(0, 0, 0, 0, mk("halt_drain", M_ADDR | M_VALID | M_HALT | M_PC, 32, 0, 31, 0, 0, 1));

    // Out-of-range redirect in HALT is ignored.
    cyc(0, 0, 1, 33, mk("halt_redir33", M_ADDR | M_VALID | M_HALT, 32, 0, 0, 0, 0, 1));
    // In-range redirect leaves HALT.
    cyc(0, 0, 1, 2, mk("halt_redir2", M_ADDR | M_VALID | M_HALT, 2, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, mk("after2", M_ALL, 3, 1, 2, 3, rom[2], 0));
    cyc(0, 0, 0, 0, mk("after2b", M_ALL, 4, 1, 3, 4, rom[3], 0));

    // Out-of-range redirect in RUN halts with no further capture.
    cyc(0, 0, 1, 40, mk("redir40", M_ALL, 40, 0, 3, 4, 0, 1));
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, mk("halt40", M_ALL, 40, 0, 3, 4, 0, 1));

    // Mid-run reset pulse.
    cyc(1, 0, 0, 0, mk("rst_pulse", M_ALL, 0, 0, 0, 0, 0, 0));
    e = mk("boot2", M_ADDR | M_VALID | M_HALT | M_CNT, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, e);

    // Counter workload: 5 advances, 2 stalls, 1 redirect.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, mk("cnt_fetch", M_ALL, i + 1, 1, i, i + 1, rom[i], 0));
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, mk("cnt_stall", M_ALL, 5, 1, 4, 5, rom[4], 0));
    e = mk("cnt_redir", M_ADDR | M_VALID | M_HALT | M_CNT, 0, 0, 0, 0, 0, 0);
    e.cf = 32'd5; e.cs = 32'd2; e.cl = 32'd1;
    cyc(0, 0, 1, 0, e);
    e = mk("cnt_rst", M_ALL | M_CNT, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, e);
    cyc(0, 0, 0, 0, mk("final_boot", M_ADDR | M_VALID | M_HALT, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
